delta_sigma_decimator: RTL and testbench
========================================

// Module: delta_sigma_decimator
// PURPOSE
//  Receive-side counterpart of the 14-bit delta-sigma modulator. Converts a 1-bit
//  delta-sigma bitstream back to signed PCM words with a 3rd-order CIC (sinc^3)
//  decimator: 3 integrators at bit rate, 3 combs at word rate, scale, saturate.
//  Sits after the bitstream source; feeds the interpolator/FIR chain in reverse.
// PARAMETERS
//  DECIM   64  decimation ratio; power of 2, 4..256
//  OUT_W   14  output word width, signed two's complement
//  localparam LOG2D = log2(DECIM); ACC_W = 3*LOG2D+2 (20 @ default);
//  localparam SHIFT = 3*LOG2D+1-OUT_W (5 @ default); SHIFT >= 0 is required
// PORTS
//  clk            in   1      single system clock, all logic on rising edge
//  reset          in   1      synchronous, active-low reset
//  data_in        in   1      delta-sigma bit: 1 -> +1, 0 -> -1
//  data_in_valid  in   1      data_in is sampled only on edges where this is 1
//  data_out       out  OUT_W  decimated PCM word, signed
//  data_valid     out  1      1-cycle strobe: data_out is new this cycle
// BEHAVIOUR
//  - Reset (reset==0 at an edge): integrators i1..i3, comb delays d1..d3, decim
//    counter, data_out=0, data_valid=0. Applies mid-frame: partial frame is
//    discarded and the counter restarts at 0.
//  - Accepted bit (data_in_valid==1): x=+1/-1; i1+=x; i2+=i1_new; i3+=i2_new
//    (the chain updates so that after n accepted bits from reset i1=sum x,
//    i2=sum i1, i3=sum i2). All ACC_W wide; wrap modulo 2^ACC_W, never saturate
//    (wrap is required for CIC correctness).
//  - data_in_valid==0: integrators and counter hold; gaps of any length are legal.
//  - Counter counts accepted bits 0..DECIM-1; the edge accepting bit DECIM-1
//    wraps it to 0 and registers an internal decimate strobe.
//  - Edge after the strobe: sample s=i3; c1=s-d1; c2=c1-d2; c3=c2-d3 (ACC_W,
//    modulo); update d1=s, d2=c1, d3=c2; y = c3 >>> SHIFT (arithmetic); saturate y
//    to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register to data_out; data_valid=1.
//  - Latency: data_valid is high for exactly one cycle, the cycle after the edge
//    following the edge that accepted bit DECIM-1. data_out holds its value between
//    strobes. One strobe per DECIM accepted bits, independent of gaps.
//  - A strobe and an accepted bit in the same cycle are independent: the
//    integrators keep running, and the sampled i3 is the value after bit DECIM-1.
//  - Full-scale: all +1 settles to c3=+2^(3*LOG2D) -> 2^(OUT_W-1) -> saturated to
//    2^(OUT_W-1)-1. All -1 gives exactly -2^(OUT_W-1) with no clipping.
//  - Settling: the first 2 words after reset are a transient (comb delays start
//    at 0). From the 3rd word on, output is the steady-state filtered value.
// TESTING
//  - All-ones, data_in_valid=1 every cycle, DECIM=64 -> words 1430, 6890, then
//    8191 (saturated) from word 3 on; strobe every 64 cycles.
//  - All-zeros -> words -1430, -6890, then -8192 steady (no saturation flag/clip).
//  - Repeating 1,0 pattern -> word 3 onward exactly 0; repeating 1,1,1,0 -> word
//    3 onward exactly 4096.
//  - All-ones with data_in_valid randomly low 50% of the time -> same word
//    sequence as the gap-free case; strobe only after each 64th accepted bit.
//  - reset=0 for 1 cycle at accepted bit 30 of frame 2 -> data_out=0 and
//    data_valid=0 next cycle; the following strobe comes after 64 more accepted
//    bits, and the words repeat 1430, 6890, 8191.
//  - Reset held low with data_in_valid=1 toggling -> data_valid never asserts and
//    data_out stays 0; the integrators do not advance.

Source files
------------

// File: rtl/delta_sigma_decimator.sv
`default_nettype none
// ============================================================================
// Module      : delta_sigma_decimator
// Description : Third-order CIC (sinc^3) decimator. Turns a 1-bit delta-sigma
//               bitstream (1 -> +1, 0 -> -1) into signed PCM words. Three
//               integrators run at the bit rate, three combs at the word rate,
//               and the result is scaled and saturated to OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module delta_sigma_decimator #(
    parameter int DECIM = 64,   // decimation ratio, power of 2 in 4..256
    parameter int OUT_W = 14    // output word width, signed
) (
    input  logic                    clk,
    input  logic                    reset,          // synchronous, active-low
    input  logic                    data_in,
    input  logic                    data_in_valid,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    data_valid
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = 3 * LOG2D + 2;
    localparam int SHIFT = 3 * LOG2D + 1 - OUT_W;

    // Saturation bounds expressed at accumulator width so they compare
    // directly against the shifted comb output.
    localparam logic signed [ACC_W-1:0] c_out_max = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_out_min = ~c_out_max;

    // Integrator state and decimation counter
    logic [ACC_W-1:0] r_i1;
    logic [ACC_W-1:0] r_i2;
    logic [ACC_W-1:0] r_i3;
    logic [LOG2D-1:0] r_count;
    logic             r_decim;

    // Comb delay line
    logic [ACC_W-1:0] r_d1;
    logic [ACC_W-1:0] r_d2;
    logic [ACC_W-1:0] r_d3;

    // Combinational next-state and output path
    logic [ACC_W-1:0]        w_x;
    logic [ACC_W-1:0]        w_i1_next;
    logic [ACC_W-1:0]        w_i2_next;
    logic [ACC_W-1:0]        w_i3_next;
    logic [ACC_W-1:0]        w_c1;
    logic [ACC_W-1:0]        w_c2;
    logic signed [ACC_W-1:0] w_c3;
    logic signed [ACC_W-1:0] w_y;
    logic [OUT_W-1:0]        w_sat;
    logic                    w_last_bit;

    // Integrator chain: each stage adds the freshly updated previous stage,
    // so after n bits i1=sum x, i2=sum i1, i3=sum i2. All arithmetic wraps.
    always_comb begin
        w_x        = data_in ? ACC_W'(1) : {ACC_W{1'b1}};
        w_i1_next  = r_i1 + w_x;
        w_i2_next  = r_i2 + w_i1_next;
        w_i3_next  = r_i3 + w_i2_next;
        w_last_bit = (r_count == LOG2D'(DECIM - 1));
    end

    // Comb chain on the registered i3 sample, then scale and saturate.
    always_comb begin
        w_c1 = r_i3 - r_d1;
        w_c2 = w_c1 - r_d2;
        w_c3 = w_c2 - r_d3;
        w_y  = w_c3 >>> SHIFT;
        if (w_y > c_out_max) begin
            w_sat = c_out_max[OUT_W-1:0];
        end else if (w_y < c_out_min) begin
            w_sat = c_out_min[OUT_W-1:0];
        end else begin
            w_sat = w_y[OUT_W-1:0];
        end
    end

    // Bit-rate integrators and decimation counter; hold while input is idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_i1    <= '0;
            r_i2    <= '0;
            r_i3    <= '0;
            r_count <= '0;
            r_decim <= 1'b0;
        end else begin
            r_decim <= 1'b0;
            if (data_in_valid) begin
                r_i1    <= w_i1_next;
                r_i2    <= w_i2_next;
                r_i3    <= w_i3_next;
                r_count <= r_count + LOG2D'(1);
                r_decim <= w_last_bit;
            end
        end
    end

    // Word-rate combs and output register. The integrators may accept a new
    // bit on this same edge; r_i3 still holds the value after the last bit
    // of the frame, which is the one sampled here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= r_decim;
            if (r_decim) begin
                r_d1     <= r_i3;
                r_d2     <= w_c1;
                r_d3     <= w_c2;
                data_out <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delta_sigma_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_delta_sigma_decimator
// Description : Directed, table-driven bench for the sinc^3 decimator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delta_sigma_decimator;

    localparam int DECIM = 64;
    localparam int OUT_W = 14;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    data_in = 1'b0;
    logic                    data_in_valid = 1'b0;
    logic signed [OUT_W-1:0] data_out;
    logic                    data_valid;

    delta_sigma_decimator #(
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .data_valid    (data_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int hold_err = 0;
    int q_word[$];
    int q_pos[$];

    typedef struct {
        logic [3:0] pat;     // bit k of the stream is pat[k % period]
        int         period;
        bit         full;    // also check the two transient words
        int         w1;
        int         w2;
        int         w3;      // steady-state word (3rd onward)
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance an edge, sample 1 time unit later.
    // prev = accepted bits before this edge; a strobe seen now belongs to
    // a frame that ended at exactly that many accepted bits.
    task automatic step(input logic b, input logic v);
        int prev;
        data_in       = b;
        data_in_valid = v;
        prev = acc_cnt;
        if (v && reset) acc_cnt++;
        @(posedge clk);
        #1;
        if (data_valid) begin
            q_word.push_back(int'(data_out));
            q_pos.push_back(prev);
        end else if (q_word.size() > 0) begin
            if (int'(data_out) != q_word[q_word.size()-1]) hold_err++;
        end else if (data_out != '0) begin
            hold_err++;
        end
    endtask

    task automatic clear_log();
        acc_cnt  = 0;
        hold_err = 0;
        q_word.delete();
        q_pos.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
        clear_log();
    endtask

    // Feed nbits accepted bits (optionally with random idle cycles), then
    // idle a few cycles so the final strobe is observed.
    task automatic feed(input logic [3:0] pat, input int period, input int nbits, input bit gaps);
        int   cyc;
        logic v;
        cyc = 0;
        while (acc_cnt < nbits && cyc < 20 * nbits + 100) begin
            v = gaps ? logic'($urandom_range(0, 1)) : 1'b1;
            step(pat[acc_cnt % period], v);
            cyc++;
        end
        check("accepted_bits", acc_cnt, nbits);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    endtask

    task automatic check_words(input string tag, input int n, input bit full,
                               input int w1, input int w2, input int w3);
        int exp;
        check($sformatf("%s_count", tag), q_word.size(), n);
        for (int j = 0; j < n; j++) begin
            if (j < q_word.size()) begin
                exp = (j == 0) ? w1 : (j == 1) ? w2 : w3;
                check($sformatf("%s_pos%0d", tag, j + 1), q_pos[j], DECIM * (j + 1));
                if (full || j >= 2)
                    check($sformatf("%s_word%0d", tag, j + 1), q_word[j], exp);
            end
        end
        check($sformatf("%s_hold", tag), hold_err, 0);
    endtask

    initial begin
        int dv_seen;
        int out_nz;

        vecs[0] = '{pat: 4'b1111, period: 1, full: 1'b1, w1: 1430,  w2: 6890,  w3: 8191};
        vecs[1] = '{pat: 4'b0000, period: 1, full: 1'b1, w1: -1430, w2: -6890, w3: -8192};
        vecs[2] = '{pat: 4'b0101, period: 2, full: 1'b0, w1: 0,     w2: 0,     w3: 0};
        vecs[3] = '{pat: 4'b0111, period: 4, full: 1'b0, w1: 0,     w2: 0,     w3: 4096};

        // Table-driven patterns, each from a fresh reset
        for (int k = 0; k < 4; k++) begin
            do_reset();
            check($sformatf("v%0d_rst_out", k), int'(data_out), 0);
            check($sformatf("v%0d_rst_valid", k), int'(data_valid), 0);
            feed(vecs[k].pat, vecs[k].period, 4 * DECIM, 1'b0);
            check_words($sformatf("v%0d", k), 4, vecs[k].full,
                        vecs[k].w1, vecs[k].w2, vecs[k].w3);
        end

        // All-ones with random idle cycles: same words, strobes per 64 bits
        do_reset();
        feed(4'b1111, 1, 3 * DECIM, 1'b1);
        check_words("gaps", 3, 1'b1, 1430, 6890, 8191);

        // Reset pulse on accepted bit 30 of frame 2
        do_reset();
        feed(4'b1111, 1, DECIM + 30, 1'b0);
        check_words("pre_rst", 1, 1'b1, 1430, 0, 0);
        reset = 1'b0;
        step(1'b1, 1'b1);
        check("midrst_out", int'(data_out), 0);
        check("midrst_valid", int'(data_valid), 0);
        reset = 1'b1;
        clear_log();
        feed(4'b1111, 1, 3 * DECIM, 1'b0);
        check_words("post_rst", 3, 1'b1, 1430, 6890, 8191);

        // Reset held low with valid toggling: nothing moves
        reset = 1'b0;
        dv_seen = 0;
        out_nz  = 0;
        for (int i = 0; i < 2 * DECIM + 10; i++) begin
            step(1'b1, logic'(i % 2 == 0));
            if (data_valid) dv_seen++;
            if (data_out != '0) out_nz++;
        end
        check("held_rst_valid", dv_seen, 0);
        check("held_rst_out", out_nz, 0);
        reset = 1'b1;
        clear_log();
        feed(4'b1111, 1, DECIM, 1'b0);
        check_words("after_hold", 1, 1'b1, 1430, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
